i2c_read_byte: RTL
==================

Name: i2c_read_byte

Overview:
- I2C master byte-level reader, the receive-side counterpart of the master byte writer.
- On command, clocks eight data bits in from the slave on SDA, MSB first, and presents the assembled byte.
- On separate commands, drives the master ACK or NACK bit back to the slave.
- Sits under the I2C controller FSM beside the byte writer; both share SCL/SDA through the controller's open-drain mux.

Parameters:
QUARTER_CYCLES, 4, clock cycles per quarter SCL bit period (>=1); one bit = 4*QUARTER_CYCLES clocks

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
go  input  1  request; level, sampled only in IDLE
command  input  3  operation select (encodings below)
sda_in  input  1  sampled SDA line
scl_in  input  1  sampled SCL line (used only with stretch feature)
scl  output  1  SCL drive; 1 = released/high
sda_oe  output  1  1 = pull SDA low, 0 = release
data  output  8  last byte received
finish  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset); polarity and synchronicity fixed.
- Reset values: scl=1, sda_oe=0, data=8'h00, finish=0, state=IDLE, counters=0.
- Commands: CMD_READ=3'b010, CMD_ACK=3'b111, CMD_NACK=3'b101. Any other value with go=1 in IDLE causes finish=1 on the next cycle, with no bus activity and data unchanged.
- States:
  - IDLE: scl=1, sda_oe=0. go=1 latches command and enters BIT. The bit counter loads 7 for READ and 0 for ACK/NACK.
  - BIT: four quarters q0..q3, each QUARTER_CYCLES clocks.
    - q0: scl=0; sda_oe set for this bit (READ: 0, ACK: 1, NACK: 0).
    - q1, q2: scl=1.
    - q3: scl=0.
    - READ samples sda_in on the q1->q2 boundary and shifts it into an internal shift register at LSB, MSB first.
    - At the end of q3: if bit counter=0, go to DONE; else decrement the counter and restart at q0.
  - DONE (one cycle): finish=1, scl=0, sda_oe=0. On READ, data<=shift register in this cycle. Next state is IDLE.
- sda_oe changes only while scl=0 (q0 entry or DONE), never while scl=1.
- Latency from the go-accept edge to finish high:
  - READ: 32*QUARTER_CYCLES+1 cycles.
  - ACK/NACK: 4*QUARTER_CYCLES+1 cycles.
- If go is still high in the IDLE cycle after DONE, a new operation starts (back-to-back). Otherwise the block stays in IDLE.
- go and command are ignored outside IDLE; command is latched at accept.
- data holds its value between READ completions; ACK/NACK never modify data.
- Reset mid-operation: abort immediately, return to reset values, no finish pulse, partial byte discarded.
- Counters wrap never; quarter counter width is clog2(QUARTER_CYCLES)+1.

Optional Feature:
- Macro I2C_READ_CLOCK_STRETCH_EN.
- Defined: in q1/q2, the quarter counter holds while scl_in=0, so a slave stretching SCL extends the high phase. Sampling occurs only after scl_in=1 has been seen and q1 has completed. Latency grows by the stretched cycles.
- Undefined: scl_in is ignored and timing is fixed as above.

Decomposition:
- Shared package i2c_pkg holds the command localparams for the byte writer and this block: CMD_IDLE 000, CMD_START 001, CMD_READ 010, CMD_WRITE 011, CMD_STOP 100, CMD_NACK 101, CMD_ACK 111.
- i2c_pkg also holds the state encodings.
- One sub-module, i2c_bit_timer: quarter counter/phase generator with hold input, outputting quarter index plus end-of-quarter and end-of-bit strobes. It is reusable by the byte writer.

Test Plan:
- Reset held 2 cycles -> scl=1, sda_oe=0, data=00, finish=0.
- QUARTER_CYCLES=4, go+CMD_READ, slave model drives 0xA5 changing sda_in only in q0 -> data=0xA5, finish pulse exactly 129 cycles after accept, sda_oe=0 throughout, 8 SCL high pulses of 8 cycles each.
- go+CMD_ACK -> sda_oe=1 from q0 through q3 of one bit, one SCL pulse, finish at 17 cycles, data unchanged (0xA5).
- go+CMD_NACK, then go held high with CMD_READ and slave data 0x3C -> NACK bit has sda_oe=0; READ starts the cycle after finish; data=0x3C.
- Reset asserted after 3 READ bits -> next cycle scl=1, sda_oe=0, data=00, no finish; subsequent READ of 0xFF returns 0xFF.
- go+command 3'b110 -> finish next cycle, scl stays 1. With I2C_READ_CLOCK_STRETCH_EN, hold scl_in=0 for 20 cycles in bit 0 -> READ finish at 149 cycles, data correct.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller command codes and byte-level FSM state encodings.
package i2c_pkg;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;
    localparam logic [2:0] CMD_NACK  = 3'b101;
    localparam logic [2:0] CMD_ACK   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Commands the read-side byte engine actually puts on the bus.
    function automatic logic rd_cmd_valid(input logic [2:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_ACK) || (cmd == CMD_NACK);
    endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit phase generator: counts QUARTER_CYCLES clocks per quarter, four quarters per bit.
module i2c_bit_timer #(
    parameter int QUARTER_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_i,
    input  logic       hold_i,
    output logic [1:0] quarter_o,
    output logic       end_q_o,
    output logic       end_bit_o
);

    localparam int QW = $clog2(QUARTER_CYCLES) + 1;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER_CYCLES - 1);

    logic [QW-1:0] qcnt_q;
    logic [1:0]    quarter_q;

    assign end_q_o   = run_i && !hold_i && (qcnt_q == QLAST);
    assign end_bit_o = end_q_o && (quarter_q == 2'd3);
    assign quarter_o = quarter_q;

    // Parked at q0/count 0 whenever not running, so every bit starts aligned.
    always_ff @(posedge clock) begin
        if (reset || !run_i) begin
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
        end else if (!hold_i) begin
            if (qcnt_q == QLAST) begin
                qcnt_q    <= '0;
                quarter_q <= quarter_q + 2'd1;
            end else begin
                qcnt_q <= qcnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_read_byte.sv
// I2C master byte reader: READ clocks in 8 bits MSB first, ACK/NACK drives one reply bit.
// Define I2C_READ_CLOCK_STRETCH_EN to let a slave stretch the SCL high phase via scl_in.
module i2c_read_byte
    import i2c_pkg::*;
#(
    parameter int QUARTER_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] command,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl,
    output logic       sda_oe,
    output logic [7:0] data,
    output logic       finish,
    output logic [1:0] dbg_state
);

    state_t     state_q;
    logic [2:0] cmd_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic       scl_q;
    logic       sda_oe_q;
    logic [7:0] data_q;
    logic       finish_q;

    logic [1:0] quarter;
    logic       end_q;
    logic       end_bit;
    logic       hold;

`ifdef I2C_READ_CLOCK_STRETCH_EN
    assign hold = (state_q == ST_BIT) && ((quarter == 2'd1) || (quarter == 2'd2)) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    i2c_bit_timer #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run_i     (state_q == ST_BIT),
        .hold_i    (hold),
        .quarter_o (quarter),
        .end_q_o   (end_q),
        .end_bit_o (end_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            data_q   <= 8'h00;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                    if (go) begin
                        cmd_q <= command;
                        if (rd_cmd_valid(command)) begin
                            state_q  <= ST_BIT;
                            scl_q    <= 1'b0;
                            sda_oe_q <= (command == CMD_ACK);
                            bitcnt_q <= (command == CMD_READ) ? 3'd7 : 3'd0;
                        end else begin
                            // Unknown command: acknowledge without touching the bus.
                            state_q  <= ST_DONE;
                            finish_q <= 1'b1;
                        end
                    end
                end
                ST_BIT: begin
                    if (end_q && (quarter == 2'd1) && (cmd_q == CMD_READ))
                        shift_q <= {shift_q[6:0], sda_in};
                    if (end_bit) begin
                        scl_q <= 1'b0;
                        if (bitcnt_q == 3'd0) begin
                            state_q  <= ST_DONE;
                            finish_q <= 1'b1;
                            sda_oe_q <= 1'b0;
                            if (cmd_q == CMD_READ)
                                data_q <= shift_q;
                        end else begin
                            bitcnt_q <= bitcnt_q - 3'd1;
                        end
                    end else if (end_q) begin
                        // SCL is high during the quarter about to start if it is q1 or q2.
                        scl_q <= (quarter == 2'd0) || (quarter == 2'd1);
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign scl       = scl_q;
    assign sda_oe    = sda_oe_q;
    assign data      = data_q;
    assign finish    = finish_q;
    assign dbg_state = state_q;

endmodule
